// File: rtl/sub_16bit_csa_pipe.sv
`default_nettype none
// ============================================================================
// Module   : sub_16bit_csa_pipe
// Purpose  : 16-bit subtractor built as a 4-stage carry-select pipeline,
//            one 4-bit slice per stage, with valid/ready flow control.
// Revision : 1.0
// ============================================================================
module sub_16bit_csa_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        bin,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] diff,
    output logic        bout,
    output logic        ovf,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int c_NUM_STAGES = 4;

    // Index 0 is the operand capture register; index k feeds slice k.
    logic [c_NUM_STAGES:0]   r_vld;
    logic [15:0]             r_a  [0:c_NUM_STAGES-1];
    logic [15:0]             r_bn [0:c_NUM_STAGES-1];
    logic [15:0]             r_d  [0:c_NUM_STAGES-1];
    logic [c_NUM_STAGES-1:0] r_c;

    logic [15:0] r_diff;
    logic        r_bout;
    logic        r_ovf;

    logic [4:0]  w_sum0 [0:c_NUM_STAGES-1];
    logic [4:0]  w_sum1 [0:c_NUM_STAGES-1];
    logic [4:0]  w_sel  [0:c_NUM_STAGES-1];
    logic [15:0] w_d    [0:c_NUM_STAGES-1];
    logic        w_ovf;
    logic        w_stall;

    assign w_stall   = r_vld[c_NUM_STAGES] & ~out_ready;
    assign in_ready  = ~w_stall;
    assign out_valid = r_vld[c_NUM_STAGES];
    assign diff      = r_diff;
    assign bout      = r_bout;
    assign ovf       = r_ovf;

    // Both carry hypotheses are formed up front; the incoming carry only muxes.
    always_comb begin
        for (int k = 0; k < c_NUM_STAGES; k++) begin
            w_sum0[k] = {1'b0, r_a[k][4*k +: 4]} + {1'b0, r_bn[k][4*k +: 4]};
            w_sum1[k] = {1'b0, r_a[k][4*k +: 4]} + {1'b0, r_bn[k][4*k +: 4]} + 5'd1;
            w_sel[k]  = r_c[k] ? w_sum1[k] : w_sum0[k];
            w_d[k]    = r_d[k];
            w_d[k][4*k +: 4] = w_sel[k][3:0];
        end
    end

    // Operands differ in sign and result sign differs from the minuend.
    assign w_ovf = (r_a[c_NUM_STAGES-1][15] == r_bn[c_NUM_STAGES-1][15]) &&
                   (w_d[c_NUM_STAGES-1][15] != r_a[c_NUM_STAGES-1][15]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld  <= '0;
            r_diff <= '0;
            r_bout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (!w_stall) begin
            r_vld  <= {r_vld[c_NUM_STAGES-1:0], in_valid};
            r_a[0] <= a;
            r_bn[0] <= ~b;
            r_c[0] <= ~bin;
            r_d[0] <= '0;
            for (int k = 0; k < c_NUM_STAGES-1; k++) begin
                r_a[k+1]  <= r_a[k];
                r_bn[k+1] <= r_bn[k];
                r_c[k+1]  <= w_sel[k][4];
                r_d[k+1]  <= w_d[k];
            end
            // Output only loads on a real result so bubbles leave it untouched.
            if (r_vld[c_NUM_STAGES-1]) begin
                r_diff <= w_d[c_NUM_STAGES-1];
                r_bout <= ~w_sel[c_NUM_STAGES-1][4];
                r_ovf  <= w_ovf;
            end
        end
    end

endmodule
`default_nettype wire
